alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
Iterative unsigned multiply/divide sequencer that drives the shared 32-bit ALU over 32 cycles to implement MULU, MULHU, DIVU and REMU. It uses only the ALU add and subtract operations; carry and borrow are recovered by comparing the ALU result against SrcA. It sits beside the execute stage and owns the ALU operand/control inputs while busy. The execute-stage mux selects this block's ALU drive whenever busy=1.

Parameters:
ADD_CTRL, 3'b000, ALUControl encoding for add.
SUB_CTRL, 3'b001, ALUControl encoding for subtract.
ITERS, 32, number of iterations; equals the datapath width and is not changed.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request; accepted only when ready=1.
kill  in  1  synchronous abort; returns the block to IDLE.
op  in  2  00 MULU (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
OpA  in  32  multiplicand or dividend; sampled at accept.
OpB  in  32  multiplier or divisor; sampled at accept.
ready  out  1  high in IDLE.
busy  out  1  high in CALC.
done  out  1  one-cycle pulse; Result is valid while done is high.
Result  out  32  result register; holds its value until the next done.
SrcA  out  32  ALU operand A.
SrcB  out  32  ALU operand B.
ALUControl  out  3  ALU operation select.
ALUResult  in  32  ALU result.
Zero  in  1  ALU zero flag; unused.

Behaviour:
- Reset (async, while rst_n=0): state=IDLE, counter=0, all internal registers 0. Outputs: ready=1, busy=0, done=0, Result=0, SrcA=0, SrcB=0, ALUControl=ADD_CTRL. Reset asserted mid-operation discards that operation with no done.
- States:
  - IDLE: ready=1.
  - CALC: busy=1.
  - DONE: done=1, ready=0, busy=0.
- Accept: start=1 in IDLE at edge k latches op, A=OpA, B=OpB and clears counter.
  - Mul, or div with B≠0: IDLE→CALC.
  - Div with B=0: IDLE→DONE with Result=0xFFFFFFFF (DIVU) or OpA (REMU); done is high in the cycle after edge k.
- CALC: one iteration per edge, counter 0..31. The edge with counter=31 performs the last iteration and moves to DONE, loading Result. done is therefore high in the cycle after edge k+32. DONE→IDLE unconditionally on the next edge.
- Outside CALC: SrcA=0, SrcB=0, ALUControl=ADD_CTRL.
- Multiply iteration. Registers: Acc (init 0), Q=B (multiplier), M=A.
  - SrcA=Acc; SrcB=Q[0]?M:0; ALUControl=ADD_CTRL.
  - c = (ALUResult < SrcA), unsigned compare.
  - Acc <= {c, ALUResult[31:1]}; Q <= {ALUResult[0], Q[31:1]}.
  - Final: MULU→Q, MULHU→Acc.
- Divide iteration. Registers: R (init 0), Q=A (dividend), D=B.
  - Rs = {R[30:0], Q[31]}; t = R[31].
  - SrcA=Rs; SrcB=D; ALUControl=SUB_CTRL.
  - ok = t | !(ALUResult > SrcA), unsigned compare.
  - R <= ok ? ALUResult : Rs; Q <= {Q[30:0], ok}.
  - Final: DIVU→Q, REMU→R.
- start while busy or in DONE: ignored, no queueing.
- kill=1 in CALC or DONE: next state IDLE, no done pulse, Result unchanged.
- kill and start both high in IDLE: kill wins, request not accepted.
- ALU operands are combinational from state; ALUResult is consumed in the same cycle, so the ALU must be purely combinational.
- Only one operation is outstanding at a time.

Test Plan:
- MULU 7×6, start at edge k -> busy for 32 cycles; done high in the cycle after edge k+32; Result=0x0000002A.
- MULU and MULHU with OpA=OpB=0xFFFFFFFF -> Result 0x00000001 and 0xFFFFFFFE respectively (exercises the carry path).
- DIVU/REMU 100,7 -> 14 and 2; DIVU 0xFFFFFFFF,1 -> 0xFFFFFFFF; DIVU/REMU 0x80000000,0xFFFFFFFF -> 0 and 0x80000000 (exercises the t=1 path).
- DIVU 5,0 -> Result=0xFFFFFFFF; REMU 5,0 -> Result=5; done one cycle after accept; busy never high.
- kill at counter=10 -> no done, ready=1 next cycle, Result keeps its old value; start pulsed mid-CALC is ignored; next MULU 3×3 -> 9.
- rst_n low at counter=20 -> ready=1, busy=0, done=0 and Result=0 immediately (asynchronous); after release a DIVU 9,2 -> 4.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/response and shared-ALU signal bundle for alu_muldiv_seq
interface alu_muldiv_seq_if;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;

    modport slave (
        input  start, kill, op, OpA, OpB, ALUResult, Zero,
        output ready, busy, done, Result, SrcA, SrcB, ALUControl
    );

    modport master (
        output start, kill, op, OpA, OpB, ALUResult, Zero,
        input  ready, busy, done, Result, SrcA, SrcB, ALUControl
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - 32-cycle unsigned MULU/MULHU/DIVU/REMU sequencer driving the shared ALU
module alu_muldiv_seq #(
    parameter logic [2:0] ADD_CTRL = 3'b000,
    parameter logic [2:0] SUB_CTRL = 3'b001,
    parameter int         ITERS    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_muldiv_seq_if.slave    bus
);
    localparam int            CW   = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t       r_state, w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [1:0]   r_op;
    logic [31:0]  r_acc;
    logic [31:0]  r_q;
    logic [31:0]  r_m;
    logic [31:0]  r_result;

    logic         w_accept, w_div0, w_last;
    logic [31:0]  w_rs, w_src_a, w_src_b;
    logic [2:0]   w_ctrl;
    logic         w_carry, w_ok;
    logic [31:0]  w_acc_nx, w_q_nx;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.kill;
    assign w_div0   = bus.op[1] && (bus.OpB == 32'd0);
    assign w_last   = (r_state == S_CALC) && !bus.kill && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nx = w_div0 ? S_DONE : S_CALC;
            S_CALC: if (bus.kill) w_state_nx = S_IDLE;
                    else if (r_cnt == LAST) w_state_nx = S_DONE;
            S_DONE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Acc/R share r_acc, multiplier/dividend share r_q, multiplicand/divisor share r_m
    always_comb begin
        w_rs    = {r_acc[30:0], r_q[31]};
        w_src_a = 32'd0;
        w_src_b = 32'd0;
        w_ctrl  = ADD_CTRL;
        if (r_state == S_CALC) begin
            if (r_op[1]) begin
                w_src_a = w_rs;
                w_src_b = r_m;
                w_ctrl  = SUB_CTRL;
            end else begin
                w_src_a = r_acc;
                w_src_b = r_q[0] ? r_m : 32'd0;
            end
        end
    end

    // Carry and no-borrow are recovered by comparing the ALU output against operand A
    always_comb begin
        w_carry = bus.ALUResult < w_src_a;
        w_ok    = r_acc[31] | !(bus.ALUResult > w_src_a);
        if (r_op[1]) begin
            w_acc_nx = w_ok ? bus.ALUResult : w_rs;
            w_q_nx   = {r_q[30:0], w_ok};
        end else begin
            w_acc_nx = {w_carry, bus.ALUResult[31:1]};
            w_q_nx   = {bus.ALUResult[0], r_q[31:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= 2'd0;
            r_acc    <= 32'd0;
            r_q      <= 32'd0;
            r_m      <= 32'd0;
            r_result <= 32'd0;
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_cnt <= '0;
            r_acc <= 32'd0;
            r_q   <= bus.op[1] ? bus.OpA : bus.OpB;
            r_m   <= bus.op[1] ? bus.OpB : bus.OpA;
            if (w_div0) r_result <= bus.op[0] ? bus.OpA : 32'hFFFF_FFFF;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt + 1'b1;
            // op[0] selects the Acc/R half (MULHU, REMU) over the Q half (MULU, DIVU)
            if (w_last) r_result <= r_op[0] ? w_acc_nx : w_q_nx;
        end
    end

    assign bus.ready      = (r_state == S_IDLE);
    assign bus.busy       = (r_state == S_CALC);
    assign bus.done       = (r_state == S_DONE);
    assign bus.Result     = r_result;
    assign bus.SrcA       = w_src_a;
    assign bus.SrcB       = w_src_b;
    assign bus.ALUControl = w_ctrl;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq with a combinational ALU model
module tb_alu_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.ALUResult = (bus.ALUControl == 3'b001) ? (bus.SrcA - bus.SrcB) : (bus.SrcA + bus.SrcB);
    assign bus.Zero      = (bus.ALUResult == 32'd0);

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Launches one op; pulse_at >= 0 re-asserts start that many cycles into the operation
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int pulse_at);
        logic [31:0] exp;
        int exp_lat, n, busy_n;
        exp     = ref_op(op, a, b);
        exp_lat = (op[1] && b == 0) ? 0 : 32;
        @(negedge clk);
        bus.op = op; bus.OpA = a; bus.OpB = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0; busy_n = 0;
        while (!bus.done && n < 200) begin
            if (bus.busy) busy_n++;
            if (n == pulse_at) bus.start = 1'b1;
            if (n == pulse_at + 1) bus.start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        chk({name, " result"}, bus.Result, exp);
        chk({name, " latency"}, 32'(n), 32'(exp_lat));
        chk({name, " busy cycles"}, 32'(busy_n), 32'(exp_lat));
        @(posedge clk); #1;
        chk({name, " done pulse ends"}, {30'd0, bus.done, bus.ready}, 32'd1);
        chk({name, " result held"}, bus.Result, exp);
    endtask

    initial begin
        logic [31:0] prev;
        int dn;
        bus.start = 1'b0; bus.kill = 1'b0; bus.op = 2'd0; bus.OpA = 32'd0; bus.OpB = 32'd0;

        vecs[0]  = '{2'd0, 32'd7,          32'd6,          32'h0000_002A};
        vecs[1]  = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[2]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[3]  = '{2'd2, 32'd100,        32'd7,          32'd14};
        vecs[4]  = '{2'd3, 32'd100,        32'd7,          32'd2};
        vecs[5]  = '{2'd2, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[6]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[8]  = '{2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{2'd3, 32'd5,          32'd0,          32'd5};
        vecs[10] = '{2'd1, 32'h0001_0000,  32'h0001_0000,  32'd1};

        #12;
        chk("reset flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
        chk("reset Result", bus.Result, 32'd0);
        chk("reset SrcA/SrcB", bus.SrcA | bus.SrcB, 32'd0);
        chk("reset ALUControl", 32'(bus.ALUControl), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            chk($sformatf("vec%0d model", i), ref_op(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, -1);
        end

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op($sformatf("rand%0d op%0d", i, op), op, a, b, -1);
        end

        chk("idle SrcA", bus.SrcA, 32'd0);
        chk("idle ALUControl", 32'(bus.ALUControl), 32'd0);

        // kill at counter=10, with kill and start overlapping afterwards in IDLE
        prev = bus.Result;
        @(negedge clk);
        bus.op = 2'd0; bus.OpA = 32'h1234; bus.OpB = 32'h10; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) bus.kill = 1'b1;
        @(posedge clk); #1;
        chk("kill ready", {30'd0, bus.ready, bus.busy}, 32'b10);
        chk("kill Result kept", bus.Result, prev);
        bus.start = 1'b1;
        @(posedge clk); #1;
        chk("kill beats start", {31'd0, bus.ready}, 32'd1);
        bus.start = 1'b0; bus.kill = 1'b0;
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
        end
        chk("kill no done", 32'(dn), 32'd0);
        chk("kill Result after", bus.Result, prev);

        do_op("mulu 3x3 with mid start", 2'd0, 32'd3, 32'd3, 5);

        // asynchronous reset at counter=20
        @(negedge clk);
        bus.op = 2'd0; bus.OpA = 32'd5; bus.OpB = 32'd5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
        chk("async reset Result", bus.Result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
        end
        chk("reset discards op", 32'(dn), 32'd0);
        do_op("divu 9/2 after reset", 2'd2, 32'd9, 32'd2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
